mem_arbiter: RTL and testbench

- Shares the single RAM port between instruction fetch (IF) and the data cache's RAM side (DC), including the cache's write-back traffic.
- Sits between the IF/cache request ports and RAM.
- Latches one request at a time and holds it on RAM until ram_data_ready.
- Returns the response with a one-cycle ready pulse and drives per-requester stall requests to ctrl.
- Data side has priority; a starvation counter guarantees IF progress; a watchdog bounds hung RAM accesses.

---
 rtl/mem_arbiter_pkg.sv | 45 ++++
 rtl/mem_arbiter_watchdog.sv | 47 ++++
 rtl/mem_arbiter.sv | 160 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg
//   Shared encodings and constants for the memory arbiter slice.
//   - Reset level, write/chip enable levels, zero word.
//   - Arbiter FSM state encoding.
//   - RAM request record latched on the arbitration edge.
package mem_arbiter_pkg;

    localparam int          REG_W         = 32;
    localparam logic        RSTN_ENABLE   = 1'b0;
    localparam logic        WRITE_ENABLE  = 1'b1;
    localparam logic        WRITE_DISABLE = 1'b0;
    localparam logic        CHIP_ENABLE   = 1'b1;
    localparam logic        CHIP_DISABLE  = 1'b0;
    localparam logic [REG_W-1:0] ZERO_WORD = '0;
    localparam logic [3:0]  SEL_ALL       = 4'b1111;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'b00,
        ARB_BUSY_DC = 2'b01,
        ARB_BUSY_IF = 2'b10
    } arb_state_e;

    // Everything that goes onto the RAM port for one access.
    typedef struct packed {
        logic [REG_W-1:0] addr;
        logic             we;
        logic [3:0]       sel;
        logic [REG_W-1:0] data;
    } ram_req_t;

    function automatic logic is_busy(input arb_state_e s);
        return (s == ARB_BUSY_DC) || (s == ARB_BUSY_IF);
    endfunction

    // Instruction fetch is always a full-word read.
    function automatic ram_req_t if_ram_req(input logic [REG_W-1:0] addr);
        ram_req_t r;
        r.addr = addr;
        r.we   = WRITE_DISABLE;
        r.sel  = SEL_ALL;
        r.data = ZERO_WORD;
        return r;
    endfunction

endpackage

// File: rtl/mem_arbiter_watchdog.sv
// arb_watchdog
//   Counts busy cycles of the current RAM access and flags a hung access.
//   Ports:
//     clk, rst     clock, asynchronous active-low reset
//     clr          clear the counter (new access granted)
//     en           access in flight, count this cycle
//     timeout      high on the edge where the count reaches TIMEOUT_CYC
//   TIMEOUT_CYC = 0 disables the timeout output.
module arb_watchdog
    import mem_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYC = 255,
    parameter int CNT_W       = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic timeout
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] busy_cnt;

    // Saturating so a disabled watchdog never wraps back into range.
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RSTN_ENABLE) begin
            busy_cnt <= '0;
        end else if (clr) begin
            busy_cnt <= '0;
        end else if (en && (busy_cnt != '1)) begin
            busy_cnt <= busy_cnt + 1'b1;
        end
    end

    // busy_cnt holds the number of completed busy cycles; the edge that
    // would make it TIMEOUT_CYC is the abort edge.
    generate
        if (TIMEOUT_CYC == 0) begin : g_off
            assign timeout = 1'b0;
        end else begin : g_on
            assign timeout = en && (busy_cnt == LAST);
        end
    endgenerate

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares one RAM port between instruction fetch (IF) and the data cache
//   (DC). One request is latched at a time and held on RAM until
//   ram_data_ready; the requester then sees a one-cycle ready pulse.
//   DC has priority; after STARVE_LIMIT consecutive losses IF is forced to
//   win. A watchdog aborts accesses that never complete and sets err_o.
//   Ports:
//     if_*        IF read request / response
//     dc_*        DC read-write request / response
//     ram_*       RAM master port (all outputs registered)
//     stallreq_*  per-requester stall request (combinational)
//     err_o       sticky watchdog-abort flag
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT_CYC  = 255,
    parameter int CNT_W        = 8
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        if_ce_i,
    input  logic [31:0] if_addr_i,
    output logic [31:0] if_data_o,
    output logic        if_ready_o,

    input  logic        dc_ce_i,
    input  logic        dc_we_i,
    input  logic [3:0]  dc_sel_i,
    input  logic [31:0] dc_addr_i,
    input  logic [31:0] dc_data_i,
    output logic [31:0] dc_data_o,
    output logic        dc_ready_o,

    output logic [31:0] ram_addr_o,
    output logic        ram_we_o,
    output logic [3:0]  ram_sel_o,
    output logic [31:0] ram_data_o,
    output logic        ram_ce_o,
    input  logic [31:0] ram_data_i,
    input  logic        ram_data_ready,

    output logic        stallreq_if_o,
    output logic        stallreq_dc_o,
    output logic        err_o
);

    localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

    arb_state_e       state;
    logic [CNT_W-1:0] starve_cnt;

    logic     if_req, dc_req;
    logic     grant_if, grant_dc;
    logic     wd_timeout;
    ram_req_t dc_req_w, if_req_w;

    // A requester whose ready pulse is up is still holding ce this cycle;
    // masking it keeps the finished access from being issued twice.
    assign if_req = if_ce_i & ~if_ready_o;
    assign dc_req = dc_ce_i & ~dc_ready_o;

    assign stallreq_if_o = if_req;
    assign stallreq_dc_o = dc_req;

    assign dc_req_w = '{addr: dc_addr_i, we: dc_we_i, sel: dc_sel_i, data: dc_data_i};
    assign if_req_w = if_ram_req(if_addr_i);

    always_comb begin
        grant_if = 1'b0;
        grant_dc = 1'b0;
        if (state == ARB_IDLE) begin
            if (dc_req && if_req) begin
                if (starve_cnt == STARVE_MAX) grant_if = 1'b1;
                else                          grant_dc = 1'b1;
            end else if (dc_req) begin
                grant_dc = 1'b1;
            end else if (if_req) begin
                grant_if = 1'b1;
            end
        end
    end

    arb_watchdog #(
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .CNT_W       (CNT_W)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clr     (grant_if | grant_dc),
        .en      (is_busy(state)),
        .timeout (wd_timeout)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RSTN_ENABLE) begin
            state      <= ARB_IDLE;
            starve_cnt <= '0;
            ram_addr_o <= ZERO_WORD;
            ram_we_o   <= WRITE_DISABLE;
            ram_sel_o  <= 4'b0000;
            ram_data_o <= ZERO_WORD;
            ram_ce_o   <= CHIP_DISABLE;
            if_data_o  <= ZERO_WORD;
            dc_data_o  <= ZERO_WORD;
            if_ready_o <= 1'b0;
            dc_ready_o <= 1'b0;
            err_o      <= 1'b0;
        end else begin
            if_ready_o <= 1'b0;
            dc_ready_o <= 1'b0;
            case (state)
                ARB_IDLE: begin
                    if (grant_dc) begin
                        ram_addr_o <= dc_req_w.addr;
                        ram_we_o   <= dc_req_w.we;
                        ram_sel_o  <= dc_req_w.sel;
                        ram_data_o <= dc_req_w.data;
                        ram_ce_o   <= CHIP_ENABLE;
                        state      <= ARB_BUSY_DC;
                        if (if_req && (starve_cnt != STARVE_MAX))
                            starve_cnt <= starve_cnt + 1'b1;
                    end else if (grant_if) begin
                        ram_addr_o <= if_req_w.addr;
                        ram_we_o   <= if_req_w.we;
                        ram_sel_o  <= if_req_w.sel;
                        ram_data_o <= if_req_w.data;
                        ram_ce_o   <= CHIP_ENABLE;
                        state      <= ARB_BUSY_IF;
                        starve_cnt <= '0;
                    end
                end

                ARB_BUSY_DC, ARB_BUSY_IF: begin
                    // Normal completion wins over a same-edge timeout.
                    if (ram_data_ready || wd_timeout) begin
                        ram_ce_o <= CHIP_DISABLE;
                        ram_we_o <= WRITE_DISABLE;
                        state    <= ARB_IDLE;
                        if (!ram_data_ready) err_o <= 1'b1;
                        if (state == ARB_BUSY_DC) begin
                            dc_ready_o <= 1'b1;
                            if (!ram_data_ready)
                                dc_data_o <= ZERO_WORD;
                            else if (ram_we_o == WRITE_DISABLE)
                                dc_data_o <= ram_data_i;
                        end else begin
                            if_ready_o <= 1'b1;
                            if_data_o  <= ram_data_ready ? ram_data_i : ZERO_WORD;
                        end
                    end
                end

                default: state <= ARB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        if_ce_i = 1'b0;
    logic [31:0] if_addr_i = '0;
    logic [31:0] if_data_o;
    logic        if_ready_o;
    logic        dc_ce_i = 1'b0;
    logic        dc_we_i = 1'b0;
    logic [3:0]  dc_sel_i = '0;
    logic [31:0] dc_addr_i = '0;
    logic [31:0] dc_data_i = '0;
    logic [31:0] dc_data_o;
    logic        dc_ready_o;
    logic [31:0] ram_addr_o;
    logic        ram_we_o;
    logic [3:0]  ram_sel_o;
    logic [31:0] ram_data_o;
    logic        ram_ce_o;
    logic [31:0] ram_data_i = '0;
    logic        ram_data_ready = 1'b0;
    logic        stallreq_if_o;
    logic        stallreq_dc_o;
    logic        err_o;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.STARVE_LIMIT(4), .TIMEOUT_CYC(8), .CNT_W(8)) dut (
        .clk(clk), .rst(rst),
        .if_ce_i(if_ce_i), .if_addr_i(if_addr_i), .if_data_o(if_data_o), .if_ready_o(if_ready_o),
        .dc_ce_i(dc_ce_i), .dc_we_i(dc_we_i), .dc_sel_i(dc_sel_i), .dc_addr_i(dc_addr_i),
        .dc_data_i(dc_data_i), .dc_data_o(dc_data_o), .dc_ready_o(dc_ready_o),
        .ram_addr_o(ram_addr_o), .ram_we_o(ram_we_o), .ram_sel_o(ram_sel_o),
        .ram_data_o(ram_data_o), .ram_ce_o(ram_ce_o), .ram_data_i(ram_data_i),
        .ram_data_ready(ram_data_ready),
        .stallreq_if_o(stallreq_if_o), .stallreq_dc_o(stallreq_dc_o), .err_o(err_o)
    );

    typedef struct packed {
        logic        if_ce;
        logic [31:0] if_addr;
        logic        dc_ce, dc_we;
        logic [3:0]  dc_sel;
        logic [31:0] dc_addr, dc_wdata;
        logic        rdy;
        logic [31:0] rdata;
    } vin_t;

    typedef struct packed {
        logic        ram_ce, ram_we;
        logic [3:0]  ram_sel;
        logic [31:0] ram_addr, ram_wdata;
        logic        if_rdy, dc_rdy;
        logic [31:0] if_data, dc_data;
        logic        st_if, st_dc, err;
    } vout_t;

    typedef struct {
        vin_t  i;
        vout_t o;
    } vec_t;

    vec_t vecs[$];

    function automatic vin_t vi(input logic ic, input logic [31:0] ia, input logic dc, input logic dw,
                                input logic [3:0] ds, input logic [31:0] da, input logic [31:0] dd,
                                input logic r, input logic [31:0] rd);
        vin_t v;
        v.if_ce = ic; v.if_addr = ia; v.dc_ce = dc; v.dc_we = dw; v.dc_sel = ds;
        v.dc_addr = da; v.dc_wdata = dd; v.rdy = r; v.rdata = rd;
        return v;
    endfunction

    function automatic vout_t vo(input logic ce, input logic we, input logic [3:0] sel,
                                 input logic [31:0] addr, input logic [31:0] wd,
                                 input logic ir, input logic dr, input logic [31:0] id,
                                 input logic [31:0] dd, input logic si, input logic sd, input logic e);
        vout_t v;
        v.ram_ce = ce; v.ram_we = we; v.ram_sel = sel; v.ram_addr = addr; v.ram_wdata = wd;
        v.if_rdy = ir; v.dc_rdy = dr; v.if_data = id; v.dc_data = dd;
        v.st_if = si; v.st_dc = sd; v.err = e;
        return v;
    endfunction

    function automatic vout_t sample();
        return vo(ram_ce_o, ram_we_o, ram_sel_o, ram_addr_o, ram_data_o, if_ready_o, dc_ready_o,
                  if_data_o, dc_data_o, stallreq_if_o, stallreq_dc_o, err_o);
    endfunction

    task automatic add(input vin_t a, input vout_t b);
        vec_t v;
        v.i = a;
        v.o = b;
        vecs.push_back(v);
    endtask

    task automatic drive(input vin_t v);
        if_ce_i = v.if_ce; if_addr_i = v.if_addr;
        dc_ce_i = v.dc_ce; dc_we_i = v.dc_we; dc_sel_i = v.dc_sel;
        dc_addr_i = v.dc_addr; dc_data_i = v.dc_wdata;
        ram_data_ready = v.rdy; ram_data_i = v.rdata;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic check_vec(input string nm, input int idx, input vout_t act, input vout_t exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s[%0d] actual=%h required=%h", nm, idx, act, exp);
        end
    endtask

    // Arbitrate with both sides requesting until IF wins; returns the index
    // of the winning arbitration (0 if IF never won). IF withdraws during
    // DC's ready cycle so that every grant is a genuine contested one.
    task automatic starve_round(input logic [31:0] base, output int won_at);
        won_at = 0;
        for (int n = 1; n <= 8 && won_at == 0; n++) begin
            if_ce_i = 1'b1; if_addr_i = 32'h0000_0100;
            dc_ce_i = 1'b1; dc_we_i = 1'b0; dc_sel_i = 4'hF; dc_addr_i = base + 32'(4 * n);
            ram_data_ready = 1'b0;
            tick();
            if (ram_ce_o && ram_addr_o == 32'h0000_0100 && ram_sel_o == 4'hF && !ram_we_o)
                won_at = n;
            ram_data_ready = 1'b1; ram_data_i = 32'h55AA_0000 | 32'(n);
            tick();
            ram_data_ready = 1'b0;
            if (won_at != 0) begin if_ce_i = 1'b1; dc_ce_i = 1'b0; end
            else             begin if_ce_i = 1'b0; dc_ce_i = 1'b1; end
            tick();
        end
        if_ce_i = 1'b0; dc_ce_i = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end

    initial begin
        int won;
        int busy;
        logic seen;
        logic [31:0] wd_data;
        logic wd_err, wd_ce;
        vout_t zero;
        zero = '0;

        // reset, IDLE with stray ram_data_ready
        add(vi(0, 0, 0, 0, 0, 0, 0, 0, 0),                   vo(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        add(vi(0, 0, 0, 0, 0, 0, 0, 1, 32'hDEADBEEF),        vo(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        add(vi(0, 0, 0, 0, 0, 0, 0, 1, 32'hDEADBEEF),        vo(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        // IF read 0x40, RAM ready in cycle 2
        add(vi(1, 32'h40, 0, 0, 0, 0, 0, 0, 0),              vo(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        add(vi(1, 32'h40, 0, 0, 0, 0, 0, 0, 0),              vo(1, 0, 4'hF, 32'h40, 0, 0, 0, 0, 0, 1, 0, 0));
        add(vi(1, 32'h40, 0, 0, 0, 0, 0, 1, 32'h24020005),   vo(1, 0, 4'hF, 32'h40, 0, 0, 0, 0, 0, 1, 0, 0));
        add(vi(1, 32'h40, 0, 0, 0, 0, 0, 0, 0),              vo(0, 0, 4'hF, 32'h40, 0, 1, 0, 32'h24020005, 0, 0, 0, 0));
        add(vi(0, 0, 0, 0, 0, 0, 0, 0, 0),                   vo(0, 0, 4'hF, 32'h40, 0, 0, 0, 32'h24020005, 0, 0, 0, 0));
        // DC read 0x2000 to give dc_data_o a known value
        add(vi(0, 0, 1, 0, 4'hF, 32'h2000, 0, 0, 0),         vo(0, 0, 4'hF, 32'h40, 0, 0, 0, 32'h24020005, 0, 0, 1, 0));
        add(vi(0, 0, 1, 0, 4'hF, 32'h2000, 0, 1, 32'h11223344), vo(1, 0, 4'hF, 32'h2000, 0, 0, 0, 32'h24020005, 0, 0, 1, 0));
        add(vi(0, 0, 1, 0, 4'hF, 32'h2000, 0, 0, 0),         vo(0, 0, 4'hF, 32'h2000, 0, 0, 1, 32'h24020005, 32'h11223344, 0, 0, 0));
        add(vi(0, 0, 0, 0, 0, 0, 0, 0, 0),                   vo(0, 0, 4'hF, 32'h2000, 0, 0, 0, 32'h24020005, 32'h11223344, 0, 0, 0));
        // IF and DC write together: DC first, IF on the edge after dc_ready_o
        add(vi(1, 32'h80, 1, 1, 4'h3, 32'h1000, 32'hBEEF, 0, 0), vo(0, 0, 4'hF, 32'h2000, 0, 0, 0, 32'h24020005, 32'h11223344, 1, 1, 0));
        add(vi(1, 32'h80, 1, 1, 4'h3, 32'h1000, 32'hBEEF, 1, 32'hCAFEF00D), vo(1, 1, 4'h3, 32'h1000, 32'hBEEF, 0, 0, 32'h24020005, 32'h11223344, 1, 1, 0));
        add(vi(1, 32'h80, 1, 1, 4'h3, 32'h1000, 32'hBEEF, 0, 0), vo(0, 0, 4'h3, 32'h1000, 32'hBEEF, 0, 1, 32'h24020005, 32'h11223344, 1, 0, 0));
        add(vi(1, 32'h80, 0, 0, 0, 0, 0, 1, 32'h0C0FFEE0),   vo(1, 0, 4'hF, 32'h80, 0, 0, 0, 32'h24020005, 32'h11223344, 1, 0, 0));
        add(vi(1, 32'h80, 0, 0, 0, 0, 0, 0, 0),              vo(0, 0, 4'hF, 32'h80, 0, 1, 0, 32'h0C0FFEE0, 32'h11223344, 0, 0, 0));
        add(vi(0, 0, 0, 0, 0, 0, 0, 0, 0),                   vo(0, 0, 4'hF, 32'h80, 0, 0, 0, 32'h0C0FFEE0, 32'h11223344, 0, 0, 0));

        #12 rst = 1'b1;
        tick();

        foreach (vecs[n]) begin
            drive(vecs[n].i);
            #1;
            check_vec("vec", n, sample(), vecs[n].o);
            tick();
        end

        // Starvation: IF wins the 5th contested arbitration, twice in a row
        // (second round only holds if the counter cleared on the IF grant).
        starve_round(32'h0000_3000, won);
        check("starve_round1", 32'(won), 32'd5);
        tick();
        starve_round(32'h0000_3800, won);
        check("starve_round2", 32'(won), 32'd5);
        tick();

        // Watchdog: RAM never answers, abort after 8 busy cycles.
        dc_ce_i = 1'b1; dc_we_i = 1'b0; dc_sel_i = 4'hF; dc_addr_i = 32'h4000;
        ram_data_ready = 1'b0;
        tick();
        check("wd_err_before", 32'(err_o), 32'd0);
        busy = 0; seen = 1'b0; wd_data = 'x; wd_err = 1'b0; wd_ce = 1'b1;
        for (int c = 0; c < 20 && !seen; c++) begin
            if (dc_ready_o) begin
                seen = 1'b1; wd_data = dc_data_o; wd_err = err_o; wd_ce = ram_ce_o;
            end else begin
                if (ram_ce_o) busy++;
                tick();
            end
        end
        check("wd_ready_seen", 32'(seen), 32'd1);
        check("wd_busy_cycles", 32'(busy), 32'd8);
        check("wd_data_zero", wd_data, 32'h0);
        check("wd_ce_dropped", 32'(wd_ce), 32'd0);
        check("wd_err_set", 32'(wd_err), 32'd1);
        dc_ce_i = 1'b0;
        tick();

        // err_o stays set across a normal access
        if_ce_i = 1'b1; if_addr_i = 32'h200;
        tick();
        ram_data_ready = 1'b1; ram_data_i = 32'h600DF00D;
        tick();
        ram_data_ready = 1'b0;
        check("post_wd_if_ready", 32'(if_ready_o), 32'd1);
        check("post_wd_if_data", if_data_o, 32'h600DF00D);
        check("post_wd_err_sticky", 32'(err_o), 32'd1);
        tick();
        if_ce_i = 1'b0;
        tick();

        // Asynchronous reset in the middle of a DC access
        dc_ce_i = 1'b1; dc_we_i = 1'b1; dc_sel_i = 4'hF; dc_addr_i = 32'h5000; dc_data_i = 32'h1234;
        tick();
        check("rst_pre_ce", 32'(ram_ce_o), 32'd1);
        #2;
        rst = 1'b0;
        dc_ce_i = 1'b0;
        #1;
        check_vec("rst_async", 0, sample(), zero);
        @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            ram_data_ready = (c == 1);
            tick();
            check_vec("rst_after", c, sample(), zero);
        end
        ram_data_ready = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
